onchip_ram_avmm: RTL and testbench
==================================

Name: onchip_ram_avmm

Overview:
- Parametrised single-port on-chip RAM with an Avalon-MM slave interface; next generation of the fixed 1K x 32 system memory.
- Adds the following over the fixed memory: configurable data width and depth, selectable read latency, and an explicit read/readdatavalid handshake.
- Adds a post-reset clear engine that fills the array with INIT_VALUE before the block accepts any access.
- Sits on the system interconnect as a processor data/program memory.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 1024, number of words; need not be a power of 2.
- ADDR_W, 10, word address width; must satisfy 2^ADDR_W >= DEPTH.
- READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2.
- INIT_VALUE, 0, word written to every location by the clear engine.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- reset_req  in  1  early reset warning; when high, blocks all accesses
- address  in  ADDR_W  word address
- clken  in  1  clock enable; 0 freezes the access pipeline
- chipselect  in  1  slave select
- read  in  1  read request
- write  in  1  write request
- byteenable  in  DATA_W/8  write byte lanes
- writedata  in  DATA_W  write data
- readdata  out  DATA_W  read data
- readdatavalid  out  1  readdata is valid this cycle
- waitrequest  out  1  request not accepted this cycle
- init_done  out  1  clear engine complete

Behaviour:
- Reset values: readdata=0, readdatavalid=0, waitrequest=1, init_done=0; FSM=CLEAR, clear pointer=0.
- FSM states:
  - CLEAR: each cycle writes INIT_VALUE to mem[ptr] and increments ptr. clken is ignored in this state. After writing DEPTH-1, go to READY on the next cycle.
  - READY: init_done=1. waitrequest = reset_req.
- Clear duration: exactly DEPTH cycles after reset deasserts. On the first READY cycle, waitrequest=0 (provided reset_req=0).
- Reset asserted at any time, including mid-CLEAR: return to CLEAR with ptr=0 and discard all in-flight reads (readdatavalid=0).
- Accept condition: chipselect & clken & ~waitrequest & (read|write).
- Write: byte lane i of mem[address] is updated iff byteenable[i]. Write data is visible to a read accepted in the following cycle.
- Read: an accepted read launches a token; readdata/readdatavalid appear exactly READ_LATENCY clken-enabled cycles later.
  - READ_LATENCY=2 adds an output register stage.
  - readdatavalid is a single-cycle pulse per accepted read.
  - One read per cycle is sustainable, with no bubbles.
- clken=0 in READY: no accept, no write. Pipeline stages hold their contents and readdatavalid is forced to 0. A held token emits when clken returns.
- read and write both asserted: the write is performed, the read is dropped, and no readdatavalid is generated.
- Out-of-range address (address >= DEPTH): the write is dropped; the read returns 0 with the normal readdatavalid.
- reset_req=1: waitrequest=1 and no array writes occur. In-flight reads still complete.
- readdata holds its last value when readdatavalid=0.

Test Plan:
- Reset for 3 cycles, then release with DEPTH=1024 → waitrequest stays high for exactly 1024 cycles; init_done rises on the 1025th cycle; a read of address 5 returns 0x00000000.
- Write 0xDEADBEEF to address 0x010 with byteenable=0xF, then write 0x11223344 with byteenable=0x5 → a read returns 0xDE22BE44; readdatavalid arrives 1 cycle after accept (READ_LATENCY=1) or 2 cycles after accept (READ_LATENCY=2).
- Back-to-back reads of addresses 0..7 with clken dropped for 3 cycles in the middle → exactly 8 readdatavalid pulses, in order, with correct data and none lost.
- Assert reset at clear pointer=500, hold 1 cycle → the clear restarts; waitrequest stays high for a further 1024 cycles.
- With reset_req=1, attempt a write of 0xFFFFFFFF to address 3 → waitrequest=1; a later read of address 3 returns the prior value 0.
- With DEPTH=1000, write to address 1010 then read it back → the read returns 0 with readdatavalid; address 1000-24=976 is unaffected.

Source files
------------

// File: rtl/onchip_ram_avmm_if.sv
// Avalon-MM slave bus bundle for onchip_ram_avmm.
// The master modport is the interconnect side and the slave modport is the memory side.
interface onchip_ram_avmm_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
) ();
   logic [ADDR_W-1:0]   address;
   logic                clken;
   logic                chipselect;
   logic                read;
   logic                write;
   logic [DATA_W/8-1:0] byteenable;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;
   logic                waitrequest;

   modport master (
      output address, clken, chipselect, read, write, byteenable, writedata,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, clken, chipselect, read, write, byteenable, writedata,
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/onchip_ram_avmm.sv
// Parametrised single-port on-chip RAM with an Avalon-MM slave port.
// After reset a clear engine fills every word with INIT_VALUE. The block
// accepts bus accesses only after the clear has finished. Reads complete
// READ_LATENCY clock-enabled cycles after they are accepted.
module onchip_ram_avmm #(
   parameter int                 DATA_W       = 32,
   parameter int                 DEPTH        = 1024,
   parameter int                 ADDR_W       = 10,
   parameter int                 READ_LATENCY = 1,
   parameter logic [DATA_W-1:0]  INIT_VALUE   = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  reset_req,
   onchip_ram_avmm_if.slave      bus,
   output logic                  init_done
);

   localparam int                BE_W     = DATA_W / 8;
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_ptr;
   logic                r_busy;
   logic                r_init_done;

   logic [DATA_W-1:0]   mem [DEPTH];

   // Two-stage read token pipeline. Only stage 1 is used when READ_LATENCY is 1.
   logic                r_tok1;
   logic                r_tok2;
   logic [DATA_W-1:0]   r_data1;
   logic [DATA_W-1:0]   r_data2;
   logic [DATA_W-1:0]   r_hold;

   logic                w_waitrequest;
   logic                w_in_range;
   logic                w_req;
   logic                w_wr_acc;
   logic                w_rd_acc;
   logic                w_out_tok;
   logic [DATA_W-1:0]   w_out_data;
   logic                w_rdv;

   // reset_req must block accesses in the same cycle, so it bypasses the busy register.
   assign w_waitrequest = r_busy | reset_req;
   assign w_in_range    = ({1'b0, bus.address} < DEPTH_X);
   assign w_req         = bus.chipselect & bus.clken & ~w_waitrequest;
   assign w_wr_acc      = w_req & bus.write & w_in_range;
   // When read and write are both asserted, the write wins and the read is dropped.
   assign w_rd_acc      = w_req & bus.read & ~bus.write;

   assign w_out_tok     = (READ_LATENCY == 2) ? r_tok2  : r_tok1;
   assign w_out_data    = (READ_LATENCY == 2) ? r_data2 : r_data1;
   // A held token stays invisible while clken is low and emits once clken returns.
   assign w_rdv         = w_out_tok & bus.clken;

   assign bus.waitrequest   = w_waitrequest;
   assign bus.readdatavalid = w_rdv;
   assign bus.readdata      = w_rdv ? w_out_data : r_hold;
   assign init_done         = r_init_done;

   // Control FSM: walks the clear pointer, then opens the bus for accesses.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_CLEAR;
         r_ptr       <= '0;
         r_busy      <= 1'b1;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               if (r_ptr == LAST_PTR) begin
                  r_state     <= ST_READY;
                  r_ptr       <= '0;
                  r_busy      <= 1'b0;
                  r_init_done <= 1'b1;
               end else begin
                  r_ptr       <= r_ptr + ADDR_W'(1);
               end
            end
            ST_READY: begin
               r_busy      <= 1'b0;
               r_init_done <= 1'b1;
            end
            default: begin
               r_state     <= ST_CLEAR;
               r_ptr       <= '0;
               r_busy      <= 1'b1;
               r_init_done <= 1'b0;
            end
         endcase
      end
   end

   // Array write port: the clear engine writes while in CLEAR, and bus writes with byte lanes apply while in READY.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (r_state == ST_CLEAR) begin
            mem[r_ptr] <= INIT_VALUE;
         end else if (w_wr_acc) begin
            for (int i = 0; i < BE_W; i++) begin
               if (bus.byteenable[i]) begin
                  mem[bus.address][i*8 +: 8] <= bus.writedata[i*8 +: 8];
               end
            end
         end
      end
   end

   // Read pipeline: tokens and data advance only on clock-enabled cycles. An out-of-range read returns zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tok1  <= 1'b0;
         r_tok2  <= 1'b0;
         r_data1 <= '0;
         r_data2 <= '0;
      end else if (bus.clken) begin
         r_tok1 <= w_rd_acc;
         r_tok2 <= r_tok1;
         if (w_rd_acc) begin
            r_data1 <= w_in_range ? mem[bus.address] : '0;
         end
         if (r_tok1) begin
            r_data2 <= r_data1;
         end
      end
   end

   // Last delivered word, so readdata stays stable between valid pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold <= '0;
      end else if (w_rdv) begin
         r_hold <= w_out_data;
      end
   end

endmodule

// File: tb/tb_onchip_ram_avmm.sv
// Bench for onchip_ram_avmm. Two instances share one stimulus stream:
// dut_a has DEPTH=1024 and READ_LATENCY=1, and dut_b has DEPTH=1000 and
// READ_LATENCY=2. Expected read responses are queued per instance. Each
// instance has a monitor that checks every readdatavalid pulse against its
// queue, including the clock-enabled cycle at which the pulse must arrive.
module tb_onchip_ram_avmm;

   typedef struct {
      logic [31:0] d;
      int          en;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        reset_req = 1'b0;
   logic [9:0]  address = 10'd0;
   logic        clken = 1'b1;
   logic        cs = 1'b0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [3:0]  be = 4'h0;
   logic [31:0] wdata = 32'h0;
   logic        init_a;
   logic        init_b;

   int          n_chk = 0;
   int          n_pass = 0;
   int          en_cnt = 0;
   exp_t        qa[$];
   exp_t        qb[$];

   onchip_ram_avmm_if #(.DATA_W(32), .ADDR_W(10)) ifa ();
   onchip_ram_avmm_if #(.DATA_W(32), .ADDR_W(10)) ifb ();

   assign ifa.address = address;  assign ifb.address = address;
   assign ifa.clken = clken;      assign ifb.clken = clken;
   assign ifa.chipselect = cs;    assign ifb.chipselect = cs;
   assign ifa.read = rd;          assign ifb.read = rd;
   assign ifa.write = wr;         assign ifb.write = wr;
   assign ifa.byteenable = be;    assign ifb.byteenable = be;
   assign ifa.writedata = wdata;  assign ifb.writedata = wdata;

   onchip_ram_avmm #(.DATA_W(32), .DEPTH(1024), .ADDR_W(10), .READ_LATENCY(1),
                     .INIT_VALUE(32'h0)) dut_a (
      .clk(clk), .reset(reset), .reset_req(reset_req), .bus(ifa), .init_done(init_a));

   onchip_ram_avmm #(.DATA_W(32), .DEPTH(1000), .ADDR_W(10), .READ_LATENCY(2),
                     .INIT_VALUE(32'h0)) dut_b (
      .clk(clk), .reset(reset), .reset_req(reset_req), .bus(ifb), .init_done(init_b));

   always #5 clk = ~clk;

   // Counts the clock-enabled edges so expected readdatavalid timing can be stated.
   always @(posedge clk) begin
      if (clken) en_cnt <= en_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor for dut_a: checks each readdatavalid pulse against the next queued expectation.
   always @(negedge clk) begin
      if (!reset && ifa.readdatavalid) begin
         if (qa.size() == 0) begin
            n_chk++;
            $display("FAIL a_spurious_rdv: got readdata %0h with no read pending", ifa.readdata);
         end else begin
            exp_t e;
            e = qa.pop_front();
            check("a_rdata", ifa.readdata, e.d);
            check("a_rdv_cycle", 32'(en_cnt), 32'(e.en));
         end
      end
   end

   // Monitor for dut_b: checks each readdatavalid pulse against the next queued expectation.
   always @(negedge clk) begin
      if (!reset && ifb.readdatavalid) begin
         if (qb.size() == 0) begin
            n_chk++;
            $display("FAIL b_spurious_rdv: got readdata %0h with no read pending", ifb.readdata);
         end else begin
            exp_t e;
            e = qb.pop_front();
            check("b_rdata", ifb.readdata, e.d);
            check("b_rdv_cycle", 32'(en_cnt), 32'(e.en));
         end
      end
   end

   task automatic idle(input int n, input logic ce);
      cs = 1'b0; rd = 1'b0; wr = 1'b0; clken = ce;
      repeat (n) @(posedge clk);
      #1;
      clken = 1'b1;
   endtask

   task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
      address = a; wdata = d; be = b; cs = 1'b1; wr = 1'b1; rd = 1'b0; clken = 1'b1;
      @(posedge clk);
      #1;
      cs = 1'b0; wr = 1'b0;
   endtask

   task automatic do_read(input logic [9:0] a, input logic [31:0] ea, input logic [31:0] eb);
      exp_t e;
      address = a; cs = 1'b1; rd = 1'b1; wr = 1'b0; clken = 1'b1;
      e.d = ea; e.en = en_cnt + 1; qa.push_back(e);
      e.d = eb; e.en = en_cnt + 2; qb.push_back(e);
      @(posedge clk);
      #1;
      cs = 1'b0; rd = 1'b0;
   endtask

   task automatic count_clear(input int exp_a, input int exp_b);
      int ca = 0;
      int cb = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (ifa.waitrequest) ca++;
         if (ifb.waitrequest) cb++;
         if (!ifa.waitrequest && !ifb.waitrequest) break;
      end
      check("a_clear_cycles", 32'(ca), 32'(exp_a));
      check("b_clear_cycles", 32'(cb), 32'(exp_b));
      check("a_init_done", {31'd0, init_a}, 32'd1);
      check("b_init_done", {31'd0, init_b}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      @(posedge clk);
      @(negedge clk);
      check("a_rst_wait", {31'd0, ifa.waitrequest}, 32'd1);
      check("b_rst_wait", {31'd0, ifb.waitrequest}, 32'd1);
      check("a_rst_init", {31'd0, init_a}, 32'd0);
      check("b_rst_init", {31'd0, init_b}, 32'd0);
      check("a_rst_rdv", {31'd0, ifa.readdatavalid}, 32'd0);
      check("b_rst_rdv", {31'd0, ifb.readdatavalid}, 32'd0);
      check("a_rst_rdata", ifa.readdata, 32'h0);
      check("b_rst_rdata", ifb.readdata, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      count_clear(1024, 1000);

      // Cleared content
      do_read(10'd5, 32'h0, 32'h0);

      // reset_req blocks a write
      reset_req = 1'b1;
      address = 10'd3; wdata = 32'hFFFF_FFFF; be = 4'hF; cs = 1'b1; wr = 1'b1;
      @(negedge clk);
      check("a_resetreq_wait", {31'd0, ifa.waitrequest}, 32'd1);
      check("b_resetreq_wait", {31'd0, ifb.waitrequest}, 32'd1);
      @(posedge clk);
      #1;
      cs = 1'b0; wr = 1'b0; reset_req = 1'b0;
      do_read(10'd3, 32'h0, 32'h0);

      // Byte-lane write merge
      do_write(10'h010, 32'hDEAD_BEEF, 4'hF);
      do_write(10'h010, 32'h1122_3344, 4'h5);
      do_read(10'h010, 32'hDE22_BE44, 32'hDE22_BE44);

      // An in-flight read completes while reset_req is raised
      do_read(10'h010, 32'hDE22_BE44, 32'hDE22_BE44);
      reset_req = 1'b1;
      idle(3, 1'b1);
      reset_req = 1'b0;

      // Back-to-back reads with a 3-cycle clken gap
      for (int i = 0; i < 8; i++) do_write(10'(i), 32'hC0DE_0000 | 32'(i), 4'hF);
      for (int i = 0; i < 4; i++) do_read(10'(i), 32'hC0DE_0000 | 32'(i), 32'hC0DE_0000 | 32'(i));
      idle(3, 1'b0);
      for (int i = 4; i < 8; i++) do_read(10'(i), 32'hC0DE_0000 | 32'(i), 32'hC0DE_0000 | 32'(i));
      idle(3, 1'b1);

      // read+write collision: the write lands and no response is expected
      address = 10'h030; wdata = 32'h55AA_55AA; be = 4'hF; cs = 1'b1; wr = 1'b1; rd = 1'b1;
      @(posedge clk);
      #1;
      idle(3, 1'b1);
      do_read(10'h030, 32'h55AA_55AA, 32'h55AA_55AA);

      // Out-of-range on dut_b (DEPTH=1000), in range on dut_a
      do_write(10'd1010, 32'h1234_5678, 4'hF);
      do_read(10'd1010, 32'h1234_5678, 32'h0);
      do_read(10'd976, 32'h0, 32'h0);
      idle(4, 1'b1);

      // Reset mid-clear at pointer 500 restarts the full clear
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (500) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      count_clear(1024, 1000);
      do_read(10'h010, 32'h0, 32'h0);
      idle(5, 1'b1);

      check("a_queue_drained", 32'(qa.size()), 32'd0);
      check("b_queue_drained", 32'(qb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
